// File: rtl/psum_writeback_pkg.sv
// Pipeline-wide constants for the SpMV accumulator back end: ALU lane geometry,
// output width, saturation limits and small helpers shared by the writeback slice.
package psum_writeback_pkg;

  localparam int unsigned ALU_K      = 4;
  localparam int unsigned ALU_IN_W   = 28;
  localparam int unsigned PSUM_OUT_W = 16;
  localparam int unsigned LANE_CNT_W = 3;

  localparam logic signed [PSUM_OUT_W-1:0] SAT_MAX = {1'b0, {(PSUM_OUT_W-1){1'b1}}};
  localparam logic signed [PSUM_OUT_W-1:0] SAT_MIN = {1'b1, {(PSUM_OUT_W-1){1'b0}}};

  // Occupancy classes of the lane buffer; NOFIT means a full beat no longer fits.
  typedef enum logic [1:0] {
    FillEmpty,
    FillPartial,
    FillNofit
  } fill_e;

  function automatic fill_e fill_state(int unsigned count, int unsigned depth, int unsigned k);
    fill_e st;
    if (count == 0) begin
      st = FillEmpty;
    end else if ((depth - count) < k) begin
      st = FillNofit;
    end else begin
      st = FillPartial;
    end
    return st;
  endfunction

  function automatic logic [LANE_CNT_W-1:0] clamp_lanes(logic [LANE_CNT_W-1:0] cnt,
                                                        int unsigned k);
    return (32'(cnt) > k) ? LANE_CNT_W'(k) : cnt;
  endfunction

endpackage

// File: rtl/psum_writeback_if.sv
// Beat-in / sum-out stream bundle of the partial-sum writeback stage, plus its status flags.
interface psum_writeback_if import psum_writeback_pkg::*; #(
  parameter int unsigned K     = ALU_K,
  parameter int unsigned IN_W  = ALU_IN_W,
  parameter int unsigned OUT_W = PSUM_OUT_W,
  parameter int unsigned ROW_W = 6
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W*K-1:0]     in_data;
  logic [LANE_CNT_W-1:0] in_count;

  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [ROW_W-1:0]      out_row;
  logic                  out_last;
  logic                  sat_flag;

  logic                  done;
  logic                  overflow_err;

  // Environment side: ALU producer and host consumer.
  modport master (
    output in_valid, in_data, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last, sat_flag, done, overflow_err
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, in_data, in_count, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last, sat_flag, done, overflow_err
  );

endinterface

// File: rtl/psum_mpush_fifo.sv
// Circular buffer that stores up to K lanes per cycle and releases one entry per cycle.
// Lane 0 of push_data sits in the MSBs and lands at the lowest write address.
module psum_mpush_fifo import psum_writeback_pkg::*; #(
  parameter int unsigned K     = ALU_K,
  parameter int unsigned W     = ALU_IN_W,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [LANE_CNT_W-1:0] push_n,
  input  logic [W*K-1:0]        push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic [CntW-1:0]       count
);

  logic [W-1:0]          mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [LANE_CNT_W-1:0] n_eff;

  always_comb begin
    n_eff    = push ? push_n : '0;
    wr_ptr_d = wr_ptr_q + PtrW'(n_eff);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(n_eff) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; pointer arithmetic wraps naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < K; i++) begin
      if (i < 32'(n_eff)) begin
        mem[wr_ptr_q + PtrW'(i)] <= push_data[W*(K-1-i) +: W];
      end
    end
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/psum_writeback.sv
// Partial-sum writeback: buffers valid ALU lanes, drains one sum per cycle saturated to
// OUT_W bits, tags each with its row index and pulses done after the final row.
module psum_writeback import psum_writeback_pkg::*; #(
  parameter int unsigned K        = ALU_K,
  parameter int unsigned IN_W     = ALU_IN_W,
  parameter int unsigned OUT_W    = PSUM_OUT_W,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NUM_ROWS = 64,
  parameter int unsigned ROW_W    = 6
) (
  input  logic           clk,
  input  logic           rst,
  psum_writeback_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic signed [IN_W-1:0] HiLim =
    {{(IN_W-PSUM_OUT_W){SAT_MAX[PSUM_OUT_W-1]}}, SAT_MAX};
  localparam logic signed [IN_W-1:0] LoLim =
    {{(IN_W-PSUM_OUT_W){SAT_MIN[PSUM_OUT_W-1]}}, SAT_MIN};
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(NUM_ROWS - 1);

  logic [CntW-1:0]        count;
  logic signed [IN_W-1:0] head;
  fill_e                  fill;
  logic [LANE_CNT_W-1:0]  n_lanes;
  logic                   lanes_over;
  logic                   push;
  logic                   beat_drop;
  logic                   out_valid;
  logic                   pop;
  logic [OUT_W-1:0]       sat_val;
  logic                   clip;

  logic [ROW_W-1:0]       row_q, row_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Readiness uses the registered count only, so a same-cycle pop never opens the gate.
  always_comb begin
    fill       = fill_state(32'(count), DEPTH, K);
    n_lanes    = clamp_lanes(bus.in_count, K);
    lanes_over = 32'(bus.in_count) > K;
    push       = bus.in_valid && (fill != FillNofit);
    beat_drop  = bus.in_valid && (fill == FillNofit);
    out_valid  = (fill != FillEmpty);
    pop        = out_valid && bus.out_ready;
  end

  psum_mpush_fifo #(
    .K    (K),
    .W    (IN_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_n   (n_lanes),
    .push_data(bus.in_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  always_comb begin
    sat_val = head[OUT_W-1:0];
    clip    = 1'b0;
    if (head > HiLim) begin
      sat_val = OUT_W'(SAT_MAX);
      clip    = 1'b1;
    end else if (head < LoLim) begin
      sat_val = OUT_W'(SAT_MIN);
      clip    = 1'b1;
    end
  end

  always_comb begin
    row_d  = row_q;
    done_d = 1'b0;
    err_d  = err_q | beat_drop | (push & lanes_over);
    if (pop) begin
      if (row_q == LastRow) begin
        row_d  = '0;
        done_d = 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      row_q  <= row_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.in_ready     = (fill != FillNofit);
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_valid ? sat_val : '0;
  assign bus.sat_flag     = out_valid & clip;
  assign bus.out_row      = row_q;
  assign bus.out_last     = out_valid && (row_q == LastRow);
  assign bus.done         = done_q;
  assign bus.overflow_err = err_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations on the drained stream.
module tb_psum_writeback;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  psum_writeback_if bus ();

  psum_writeback dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int q_m[$];
  int row_m  = 0;
  bit err_m  = 1'b0;
  bit done_m = 1'b0;

  // Observed pops.
  int log_data[$];
  int log_row[$];
  int log_sat[$];
  int log_last[$];
  int done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_v(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int sat_h(input int v);
    return (v > 32767 || v < -32768) ? 1 : 0;
  endfunction

  // Model update: the spec rules applied to a plain queue at each active edge.
  always @(posedge clk) begin
    bit pop_m;
    bit rdy_m;
    int n;
    logic [27:0] lane;
    if (!rst) begin
      q_m.delete();
      row_m  = 0;
      err_m  = 1'b0;
      done_m = 1'b0;
    end else begin
      pop_m  = (q_m.size() != 0) && bus.out_ready;
      rdy_m  = (16 - q_m.size()) >= 4;
      done_m = pop_m && (row_m == 63);
      if (pop_m) begin
        void'(q_m.pop_front());
        row_m = (row_m + 1) % 64;
      end
      if (bus.in_valid) begin
        if (!rdy_m) begin
          err_m = 1'b1;
        end else begin
          n = int'(bus.in_count);
          if (n > 4) begin
            n = 4;
            err_m = 1'b1;
          end
          for (int i = 0; i < n; i++) begin
            lane = bus.in_data[(3-i)*28 +: 28];
            q_m.push_back(int'($signed(lane)));
          end
        end
      end
    end
  end

  // Compare process, sampled on the inactive edge.
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (q_m.size() != 0);
      chk("in_ready", int'(bus.in_ready), ((16 - q_m.size()) >= 4) ? 1 : 0);
      chk("out_valid", int'(bus.out_valid), int'(ev));
      chk("out_data", int'($signed(bus.out_data)), ev ? sat_v(q_m[0]) : 0);
      chk("sat_flag", int'(bus.sat_flag), ev ? sat_h(q_m[0]) : 0);
      chk("out_row", int'(bus.out_row), row_m);
      chk("out_last", int'(bus.out_last), (ev && row_m == 63) ? 1 : 0);
      chk("done", int'(bus.done), int'(done_m));
      chk("overflow_err", int'(bus.overflow_err), int'(err_m));
      if (bus.done) done_seen++;
      if (bus.out_valid && bus.out_ready) begin
        log_data.push_back(int'($signed(bus.out_data)));
        log_row.push_back(int'(bus.out_row));
        log_sat.push_back(int'(bus.sat_flag));
        log_last.push_back(int'(bus.out_last));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_data.delete();
    log_row.delete();
    log_sat.delete();
    log_last.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic send(input int l0, input int l1, input int l2, input int l3, input int cnt,
                      input bit wait_rdy);
    int g = 0;
    if (wait_rdy) begin
      while (!bus.in_ready && g < 200) begin
        cyc();
        g++;
      end
      if (g >= 200) chk("in_ready_timeout", int'(bus.in_ready), 1);
    end
    bus.in_data  = {28'(l0), 28'(l1), 28'(l2), 28'(l3)};
    bus.in_count = 3'(cnt);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int g = 0;
    while (log_data.size() < n && g < 400) begin
      cyc();
      g++;
    end
    chk(name, log_data.size(), n);
  endtask

  initial begin
    int e1[4] = '{100, -5, 0, 32767};
    int e2[4] = '{32767, -32768, 32767, -32768};
    int s2[4] = '{1, 1, 1, 0};
    int e4[8] = '{1, 2, 3, 4, 11, 12, 13, 14};
    int errs;
    int lasts;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_count  = '0;
    bus.out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    cyc();

    // Single full beat, first output one cycle after accept.
    clear_log();
    bus.out_ready = 1'b1;
    send(100, -5, 0, 32767, 4, 1'b0);
    @(negedge clk);
    chk("t1_first_valid", int'(bus.out_valid), 1);
    wait_log(4, "t1_pops");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), log_data[i], e1[i]);
      chk($sformatf("t1_row%0d", i), log_row[i], i);
      chk($sformatf("t1_sat%0d", i), log_sat[i], 0);
    end
    repeat (3) cyc();

    // Saturation.
    do_reset();
    clear_log();
    send(40000, -40000, 32768, -32768, 4, 1'b1);
    wait_log(4, "t2_pops");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_data%0d", i), log_data[i], e2[i]);
      chk($sformatf("t2_sat%0d", i), log_sat[i], s2[i]);
    end
    repeat (3) cyc();

    // Backpressure and dropped beat.
    do_reset();
    clear_log();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send(b * 100, b * 100 + 1, b * 100 + 2, b * 100 + 3, 4, 1'b0);
      if (b == 2) chk("t3_ready_at12", int'(bus.in_ready), 1);
      if (b == 3) chk("t3_ready_at16", int'(bus.in_ready), 0);
    end
    send(7, 7, 7, 7, 4, 1'b0);
    chk("t3_overflow", int'(bus.overflow_err), 1);
    chk("t3_still_full", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    wait_log(16, "t3_pops");
    errs = 0;
    for (int i = 0; i < 16; i++) if (log_data[i] != (i / 4) * 100 + (i % 4)) errs++;
    chk("t3_drain_order", errs, 0);
    repeat (3) cyc();
    chk("t3_empty_after", int'(bus.out_valid), 0);

    // Partial beats, then an over-count beat.
    do_reset();
    clear_log();
    send(1, 2, 3, 99, 3, 1'b1);
    send(50, 50, 50, 50, 0, 1'b1);
    send(4, 88, 88, 88, 1, 1'b1);
    repeat (8) cyc();
    chk("t4_partial_count", log_data.size(), 4);
    chk("t4_err_clear", int'(bus.overflow_err), 0);
    send(11, 12, 13, 14, 5, 1'b1);
    chk("t4_overcount_err", int'(bus.overflow_err), 1);
    wait_log(8, "t4_pops");
    for (int i = 0; i < 8; i++) chk($sformatf("t4_data%0d", i), log_data[i], e4[i]);
    repeat (3) cyc();

    // Row wrap, out_last and done.
    do_reset();
    clear_log();
    done_seen = 0;
    for (int b = 0; b < 16; b++) send(4 * b, 4 * b + 1, 4 * b + 2, 4 * b + 3, 4, 1'b1);
    wait_log(64, "t5_pops");
    repeat (2) cyc();
    send(5, 0, 0, 0, 1, 1'b1);
    wait_log(65, "t5_extra_pop");
    errs = 0;
    lasts = 0;
    for (int i = 0; i < 64; i++) begin
      if (log_data[i] != i || log_row[i] != i) errs++;
      lasts += log_last[i];
    end
    chk("t5_order", errs, 0);
    chk("t5_last_count", lasts + log_last[64], 1);
    chk("t5_last_row63", log_last[63], 1);
    chk("t5_done_once", done_seen, 1);
    chk("t5_row_wrapped", log_row[64], 0);
    repeat (3) cyc();

    // Reset in the middle of a drain.
    do_reset();
    clear_log();
    bus.out_ready = 1'b0;
    send(1, 2, 3, 4, 5, 1'b1);
    send(5, 6, 7, 8, 4, 1'b1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("t6_pre_err", int'(bus.overflow_err), 1);
    chk("t6_pre_row", int'(bus.out_row), 1);
    done_seen = 0;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", int'(bus.out_valid), 0);
    chk("t6_out_row", int'(bus.out_row), 0);
    chk("t6_in_ready", int'(bus.in_ready), 1);
    chk("t6_err", int'(bus.overflow_err), 0);
    repeat (5) cyc();
    chk("t6_no_done", done_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
